// File: rtl/vga_timing_pkg.sv
// Raster timing constants for 640x480@60 Hz from a 100 MHz board clock.
// The pixel-colour block imports this for the visible-area bounds.
package vga_timing_pkg;

  localparam int COORD_W     = 10;   // width of hCount / vCount

  localparam int CLK_DIV     = 4;    // board clocks per pixel
  localparam int H_TOTAL     = 800;  // pixels per line including blanking
  localparam int H_SYNC      = 96;   // hSync low width, from hCount=0
  localparam int H_VIS_START = 144;  // first visible hCount
  localparam int H_VIS_END   = 783;  // last visible hCount
  localparam int V_TOTAL     = 525;  // lines per frame
  localparam int V_SYNC      = 2;    // vSync low width, from vCount=0
  localparam int V_VIS_START = 35;   // first visible vCount
  localparam int V_VIS_END   = 514;  // last visible vCount

endpackage

// File: rtl/vga_display_controller_mod_counter.sv
// Modulo-MOD counter with enable and synchronous reset. Exposes the
// registered count, the value it will take at the next edge, and a wrap
// strobe (en && count==MOD-1) used to chain counters.
module mod_counter #(
  parameter int MOD = 4,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] next,
  output logic         wrap
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: hold, increment, or wrap to zero at MOD-1; reset forces zero.
  always_comb begin
    wrap    = en && (count_q == W'(MOD - 1));
    count_d = count_q;
    if (wrap) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
    if (rst) begin
      count_d = '0;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign next  = count_d;

endmodule

// File: rtl/vga_display_controller.sv
// VGA raster timing generator. A clock divider produces the pixel strobe,
// which drives chained horizontal and vertical position counters. Sync,
// bright and frame_tick are decoded from the next-state counter values and
// registered, so they change on the same edge as hCount/vCount.
// pix_en is a free-running one-clk strobe; there is no back-pressure.
module vga_display_controller
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV     = vga_timing_pkg::CLK_DIV,
  parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int H_VIS_START = vga_timing_pkg::H_VIS_START,
  parameter int H_VIS_END   = vga_timing_pkg::H_VIS_END,
  parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int V_VIS_START = vga_timing_pkg::V_VIS_START,
  parameter int V_VIS_END   = vga_timing_pkg::V_VIS_END
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pix_en,
  output logic [COORD_W-1:0] hCount,
  output logic [COORD_W-1:0] vCount,
  output logic               hSync,
  output logic               vSync,
  output logic               bright,
  output logic               frame_tick
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  // Counters must fit the 10-bit coordinate width and the divider needs
  // at least two phases so pix_en can be registered one cycle early.
  if (CLK_DIV < 2 || H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_params
    $error("vga_display_controller: illegal timing parameters");
  end

  logic [DIV_W-1:0]   div_count, div_next;
  logic               div_wrap;
  logic [COORD_W-1:0] h_count, h_next, v_count, v_next;
  logic               h_wrap, v_wrap;

  logic pix_en_q, pix_en_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic bright_q, bright_d;
  logic frame_tick_q, frame_tick_d;

  logic unused_taps;
  assign unused_taps = ^{div_next, div_wrap, v_wrap};

  mod_counter #(.MOD(CLK_DIV), .W(DIV_W)) u_div (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .count (div_count),
    .next  (div_next),
    .wrap  (div_wrap)
  );

  mod_counter #(.MOD(H_TOTAL), .W(COORD_W)) u_hcount (
    .clk   (clk),
    .rst   (rst),
    .en    (pix_en_q),
    .count (h_count),
    .next  (h_next),
    .wrap  (h_wrap)
  );

  mod_counter #(.MOD(V_TOTAL), .W(COORD_W)) u_vcount (
    .clk   (clk),
    .rst   (rst),
    .en    (h_wrap),
    .count (v_count),
    .next  (v_next),
    .wrap  (v_wrap)
  );

  // Decode strobes and sync/visible flags from the counters' next values.
  always_comb begin
    // div reaches CLK_DIV-1 on the next edge exactly when it is CLK_DIV-2 now.
    pix_en_d     = (div_count == DIV_W'(CLK_DIV - 2));
    hsync_d      = (h_next >= COORD_W'(H_SYNC));
    vsync_d      = (v_next >= COORD_W'(V_SYNC));
    bright_d     = (h_next >= COORD_W'(H_VIS_START)) && (h_next <= COORD_W'(H_VIS_END)) &&
                   (v_next >= COORD_W'(V_VIS_START)) && (v_next <= COORD_W'(V_VIS_END));
    // A line wrap into the first line below the visible window starts the tick.
    frame_tick_d = h_wrap && (v_next == COORD_W'(V_VIS_END + 1));
  end

  // Output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_en_q     <= 1'b0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      bright_q     <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      pix_en_q     <= pix_en_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      bright_q     <= bright_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign pix_en     = pix_en_q;
  assign hCount     = h_count;
  assign vCount     = v_count;
  assign hSync      = hsync_q;
  assign vSync      = vsync_q;
  assign bright     = bright_q;
  assign frame_tick = frame_tick_q;

endmodule
